// File: rtl/traffic_pkg.sv
// Shared types and constants for the pedestrian-crossing phase sequencer.
// Phase encodings, counter width, default durations and a duration-to-counter helper.
package traffic_pkg;

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        CLEAR  = 2'd2,
        WALK   = 2'd3
    } phase_t;

    localparam int GREEN_S_DEF  = 8;
    localparam int YELLOW_S_DEF = 2;
    localparam int CLEAR_S_DEF  = 1;
    localparam int WALK_S_DEF   = 10;
    localparam int FLASH_S_DEF  = 3;

    // Durations wider than the counter are truncated, never saturated.
    function automatic logic [CNT_W-1:0] to_cnt(input int secs);
        return CNT_W'(secs);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down counter holding the seconds remaining in the current phase.
// A load always takes priority over a decrement in the same cycle.
module phase_timer
    import traffic_pkg::*;
#(
    parameter logic [CNT_W-1:0] INIT = 6'd8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    // Countdown register: reload on phase change, otherwise step once per second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= INIT;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - 6'd1;
        end else begin
            cnt <= cnt;
        end
    end

    assign last = (cnt == 6'd1);

endmodule

// File: rtl/traffic_phase_chk.sv
// Simulation checks for the phase sequencer: zero durations and a flash window
// longer than the walk phase are configuration errors.
module traffic_phase_chk
    import traffic_pkg::*;
#(
    parameter int WALK_S  = WALK_S_DEF,
    parameter int FLASH_S = FLASH_S_DEF
) (
    input logic             clk,
    input logic             rst,
    input logic [CNT_W-1:0] cnt
);

    localparam logic FLASH_OK = (to_cnt(FLASH_S) != 6'd0) && (to_cnt(FLASH_S) <= to_cnt(WALK_S));

    a_cnt_nonzero: assert property (@(posedge clk) disable iff (rst) cnt != 6'd0);
    a_flash_range: assert property (@(posedge clk) disable iff (rst) FLASH_OK);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Pedestrian-crossing phase sequencer: FSM, request latch and registered lamps.
// Optional feature macro: PED_FLASH_EN (flashing walk lamp during the last FLASH_S seconds).
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_S  = GREEN_S_DEF,
    parameter int YELLOW_S = YELLOW_S_DEF,
    parameter int CLEAR_S  = CLEAR_S_DEF,
    parameter int WALK_S   = WALK_S_DEF,
    parameter int FLASH_S  = FLASH_S_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_1s,
    input  logic             ped_btn,
    output logic             car_g,
    output logic             car_y,
    output logic             car_r,
    output logic             ped_walk,
    output logic             ped_stop,
    output logic             ped_wait,
    output logic [CNT_W-1:0] cnt_down,
    output logic [1:0]       phase,
    output logic             phase_done
);

    localparam logic [CNT_W-1:0] GREEN_C  = to_cnt(GREEN_S);
    localparam logic [CNT_W-1:0] YELLOW_C = to_cnt(YELLOW_S);
    localparam logic [CNT_W-1:0] CLEAR_C  = to_cnt(CLEAR_S);
    localparam logic [CNT_W-1:0] WALK_C   = to_cnt(WALK_S);
`ifdef PED_FLASH_EN
    localparam logic [CNT_W-1:0] FLASH_C  = to_cnt(FLASH_S);
`endif

    phase_t           state;
    phase_t           state_nxt;
    logic             ped_req;
    logic             ped_req_nxt;
    logic [CNT_W-1:0] load_val;
    logic             last;
    logic             terminal;
    logic             car_g_nxt;
    logic             car_y_nxt;
    logic             car_r_nxt;
    logic             walk_nxt;
    logic             stop_nxt;

    assign terminal   = last & pulse_1s;
    assign phase_done = terminal;
    assign phase      = state;
    assign ped_wait   = ped_req;

    phase_timer #(
        .INIT (GREEN_C)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (terminal),
        .load_val (load_val),
        .dec      (pulse_1s),
        .cnt      (cnt_down),
        .last     (last)
    );

    traffic_phase_chk #(
        .WALK_S  (WALK_S),
        .FLASH_S (FLASH_S)
    ) u_chk (
        .clk (clk),
        .rst (rst),
        .cnt (cnt_down)
    );

    // Next phase, the duration to load with it, and the request latch update.
    always_comb begin
        state_nxt   = state;
        load_val    = GREEN_C;
        ped_req_nxt = ped_req;
        if (terminal) begin
            case (state)
                GREEN:   state_nxt = (ped_req || ped_btn) ? YELLOW : GREEN;
                YELLOW:  state_nxt = CLEAR;
                CLEAR:   state_nxt = WALK;
                WALK:    state_nxt = GREEN;
                default: state_nxt = GREEN;
            endcase
        end else begin
            state_nxt = state;
        end
        case (state_nxt)
            GREEN:   load_val = GREEN_C;
            YELLOW:  load_val = YELLOW_C;
            CLEAR:   load_val = CLEAR_C;
            WALK:    load_val = WALK_C;
            default: load_val = GREEN_C;
        endcase
        // Entering WALK serves the request; a press in that same cycle is consumed too.
        if (terminal && (state == CLEAR)) begin
            ped_req_nxt = 1'b0;
        end else if (ped_btn && (state != WALK)) begin
            ped_req_nxt = 1'b1;
        end else begin
            ped_req_nxt = ped_req;
        end
    end

    // Lamp values for the phase about to be entered, so the registers track the state.
    always_comb begin
        car_g_nxt = 1'b0;
        car_y_nxt = 1'b0;
        car_r_nxt = 1'b0;
        walk_nxt  = 1'b0;
        stop_nxt  = 1'b1;
        case (state_nxt)
            GREEN:   car_g_nxt = 1'b1;
            YELLOW:  car_y_nxt = 1'b1;
            CLEAR:   car_r_nxt = 1'b1;
            WALK: begin
                car_r_nxt = 1'b1;
                stop_nxt  = 1'b0;
`ifdef PED_FLASH_EN
                // First pulse into the flash window forces 0, later pulses toggle.
                if ((state == WALK) && pulse_1s && ((cnt_down - 6'd1) <= FLASH_C)) begin
                    walk_nxt = (cnt_down > FLASH_C) ? 1'b0 : ~ped_walk;
                end else if (state == WALK) begin
                    walk_nxt = ped_walk;
                end else begin
                    walk_nxt = 1'b1;
                end
`else
                walk_nxt  = 1'b1;
`endif
            end
            default: car_g_nxt = 1'b1;
        endcase
    end

    // State, request latch and lamp registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= GREEN;
            ped_req  <= 1'b0;
            car_g    <= 1'b1;
            car_y    <= 1'b0;
            car_r    <= 1'b0;
            ped_walk <= 1'b0;
            ped_stop <= 1'b1;
        end else begin
            state    <= state_nxt;
            ped_req  <= ped_req_nxt;
            car_g    <= car_g_nxt;
            car_y    <= car_y_nxt;
            car_r    <= car_r_nxt;
            ped_walk <= walk_nxt;
            ped_stop <= stop_nxt;
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed-vector bench for traffic_phase_ctrl with default parameters.
// Lamp vector order: {car_g, car_y, car_r, ped_walk, ped_stop, ped_wait}.
module tb_traffic_phase_ctrl;

    logic       clk;
    logic       rst;
    logic       pulse_1s;
    logic       ped_btn;
    logic       car_g;
    logic       car_y;
    logic       car_r;
    logic       ped_walk;
    logic       ped_stop;
    logic       ped_wait;
    logic [5:0] cnt_down;
    logic [1:0] phase;
    logic       phase_done;
    logic [5:0] lamps;
    logic       pd;

    int n_vec;
    int n_err;

    localparam logic [5:0] L_GREEN     = 6'b100010;
    localparam logic [5:0] L_YELLOW    = 6'b010011;
    localparam logic [5:0] L_CLEAR     = 6'b001011;
    localparam logic [5:0] L_WALK      = 6'b001100;

    assign lamps = {car_g, car_y, car_r, ped_walk, ped_stop, ped_wait};

    traffic_phase_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .pulse_1s   (pulse_1s),
        .ped_btn    (ped_btn),
        .car_g      (car_g),
        .car_y      (car_y),
        .car_r      (car_r),
        .ped_walk   (ped_walk),
        .ped_stop   (ped_stop),
        .ped_wait   (ped_wait),
        .cnt_down   (cnt_down),
        .phase      (phase),
        .phase_done (phase_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One-clock pulse_1s strobe (optionally with the button), phase_done sampled mid-cycle.
    task automatic pulse(input logic btn);
        ped_btn  = btn;
        pulse_1s = 1'b1;
        @(negedge clk);
        pd = phase_done;
        @(posedge clk);
        #1;
        pulse_1s = 1'b0;
        ped_btn  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) pulse(1'b0);
    endtask

    task automatic press();
        ped_btn = 1'b1;
        @(posedge clk);
        #1;
        ped_btn = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        pulse_1s = 1'b0;
        ped_btn  = 1'b0;
        pd       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_phase", 8'(phase), 8'd0);
        check("rst_cnt", 8'(cnt_down), 8'd8);
        check("rst_lamps", 8'(lamps), 8'(L_GREEN));
        check("rst_done", 8'(phase_done), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle green cycle: 8,7..1 then reload 8, one phase_done per 8 pulses.
        for (int k = 1; k <= 8; k++) begin
            pulse(1'b0);
            check("idle_cnt", 8'(cnt_down), (k == 8) ? 8'd8 : 8'(8 - k));
            check("idle_done", 8'(pd), (k == 8) ? 8'd1 : 8'd0);
            check("idle_lamps", 8'(lamps), 8'(L_GREEN));
        end
        check("idle_phase", 8'(phase), 8'd0);

        // Button at cnt_down=5, full walk cycle.
        pulses(3);
        check("pre_btn_cnt", 8'(cnt_down), 8'd5);
        press();
        check("btn_wait", 8'(ped_wait), 8'd1);
        pulses(4);
        check("g_last_cnt", 8'(cnt_down), 8'd1);
        check("g_last_phase", 8'(phase), 8'd0);
        pulse(1'b0);
        check("y_phase", 8'(phase), 8'd1);
        check("y_cnt2", 8'(cnt_down), 8'd2);
        check("y_lamps", 8'(lamps), 8'(L_YELLOW));
        pulse(1'b0);
        check("y_cnt1", 8'(cnt_down), 8'd1);
        pulse(1'b0);
        check("c_phase", 8'(phase), 8'd2);
        check("c_cnt", 8'(cnt_down), 8'd1);
        check("c_lamps", 8'(lamps), 8'(L_CLEAR));
        pulse(1'b0);
        check("w_phase", 8'(phase), 8'd3);
        check("w_cnt", 8'(cnt_down), 8'd10);
        check("w_lamps", 8'(lamps), 8'(L_WALK));
        for (int k = 1; k <= 9; k++) begin
            pulse(1'b0);
            check("w_run_cnt", 8'(cnt_down), 8'(10 - k));
            check("w_run_lamps", 8'(lamps), 8'(L_WALK));
        end
        pulse(1'b0);
        check("w_done", 8'(pd), 8'd1);
        check("back_phase", 8'(phase), 8'd0);
        check("back_cnt", 8'(cnt_down), 8'd8);
        check("back_lamps", 8'(lamps), 8'(L_GREEN));

        // Button coincident with the green terminal pulse.
        pulses(7);
        check("co_pre_cnt", 8'(cnt_down), 8'd1);
        pulse(1'b1);
        check("co_done", 8'(pd), 8'd1);
        check("co_phase", 8'(phase), 8'd1);
        check("co_cnt", 8'(cnt_down), 8'd2);
        check("co_lamps", 8'(lamps), 8'(L_YELLOW));

        // Button during WALK is ignored; next green repeats without a walk.
        pulses(3);
        check("w2_phase", 8'(phase), 8'd3);
        pulses(3);
        press();
        check("w2_btn_lamps", 8'(lamps), 8'(L_WALK));
        check("w2_btn_cnt", 8'(cnt_down), 8'd7);
        pulses(7);
        check("g2_phase", 8'(phase), 8'd0);
        check("g2_wait", 8'(ped_wait), 8'd0);
        pulses(8);
        check("g3_done", 8'(pd), 8'd1);
        check("g3_phase", 8'(phase), 8'd0);
        check("g3_cnt", 8'(cnt_down), 8'd8);
        check("g3_lamps", 8'(lamps), 8'(L_GREEN));

        // Reset mid-WALK at cnt_down=4 aborts immediately.
        press();
        pulses(8 + 2 + 1 + 6);
        check("w3_phase", 8'(phase), 8'd3);
        check("w3_cnt", 8'(cnt_down), 8'd4);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_phase", 8'(phase), 8'd0);
        check("mid_rst_cnt", 8'(cnt_down), 8'd8);
        check("mid_rst_lamps", 8'(lamps), 8'(L_GREEN));
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulse(1'b0);
        check("post_rst_cnt", 8'(cnt_down), 8'd7);
        check("post_rst_phase", 8'(phase), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
